// File: rtl/ex_mem_pipe_if.sv
// EX->MEM pipeline bus: EX-side fields in, registered MEM-side fields and EX feedback out.
// Exception fields exist only when EX_MEM_EXCEPT_EN is defined.
interface ex_mem_pipe_if #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned ALUOP_W    = 8,
  parameter int unsigned CNT_W      = 2
);
  localparam int unsigned HILO_W = 2 * DATA_W;

  logic [REG_ADDR_W-1:0] ex_wd;
  logic                  ex_wreg;
  logic [DATA_W-1:0]     ex_wdata;
  logic                  ex_whilo;
  logic [DATA_W-1:0]     ex_hi;
  logic [DATA_W-1:0]     ex_lo;
  logic [DATA_W-1:0]     ex_mem_addr;
  logic [DATA_W-1:0]     ex_reg2;
  logic [ALUOP_W-1:0]    ex_aluop;
  logic [HILO_W-1:0]     ex_hilo_temp;
  logic [CNT_W-1:0]      ex_cnt;

  logic [REG_ADDR_W-1:0] mem_wd;
  logic                  mem_wreg;
  logic [DATA_W-1:0]     mem_wdata;
  logic                  mem_whilo;
  logic [DATA_W-1:0]     mem_hi;
  logic [DATA_W-1:0]     mem_lo;
  logic [DATA_W-1:0]     mem_mem_addr;
  logic [DATA_W-1:0]     mem_reg2;
  logic [ALUOP_W-1:0]    mem_aluop;
  logic                  mem_valid;
  logic [HILO_W-1:0]     hilo_o;
  logic [CNT_W-1:0]      cnt_o;

`ifdef EX_MEM_EXCEPT_EN
  logic [31:0]           ex_excepttype;
  logic [DATA_W-1:0]     ex_inst_addr;
  logic                  ex_in_delayslot;
  logic [31:0]           mem_excepttype;
  logic [DATA_W-1:0]     mem_inst_addr;
  logic                  mem_in_delayslot;
`endif

  modport master (
    output ex_wd, ex_wreg, ex_wdata, ex_whilo, ex_hi, ex_lo, ex_mem_addr, ex_reg2,
           ex_aluop, ex_hilo_temp, ex_cnt,
`ifdef EX_MEM_EXCEPT_EN
    output ex_excepttype, ex_inst_addr, ex_in_delayslot,
    input  mem_excepttype, mem_inst_addr, mem_in_delayslot,
`endif
    input  mem_wd, mem_wreg, mem_wdata, mem_whilo, mem_hi, mem_lo, mem_mem_addr,
           mem_reg2, mem_aluop, mem_valid, hilo_o, cnt_o
  );

  modport slave (
    input  ex_wd, ex_wreg, ex_wdata, ex_whilo, ex_hi, ex_lo, ex_mem_addr, ex_reg2,
           ex_aluop, ex_hilo_temp, ex_cnt,
`ifdef EX_MEM_EXCEPT_EN
    input  ex_excepttype, ex_inst_addr, ex_in_delayslot,
    output mem_excepttype, mem_inst_addr, mem_in_delayslot,
`endif
    output mem_wd, mem_wreg, mem_wdata, mem_whilo, mem_hi, mem_lo, mem_mem_addr,
           mem_reg2, mem_aluop, mem_valid, hilo_o, cnt_o
  );
endinterface

// File: rtl/ex_mem_pipe.sv
// EX->MEM pipeline register with flush, hold (stall_mem) and bubble (stall_ex) handling.
// Optional precise-exception fields are built in when EX_MEM_EXCEPT_EN is defined.
module ex_mem_pipe #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned ALUOP_W    = 8,
  parameter int unsigned CNT_W      = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         stall_ex,
  input  logic         stall_mem,
  input  logic         flush,
  ex_mem_pipe_if.slave bus
);
  localparam int unsigned HILO_W = 2 * DATA_W;
  localparam logic [ALUOP_W-1:0] ALUOP_NOP = '0;

  logic [REG_ADDR_W-1:0] wd_q, wd_d;
  logic                  wreg_q, wreg_d;
  logic [DATA_W-1:0]     wdata_q, wdata_d;
  logic                  whilo_q, whilo_d;
  logic [DATA_W-1:0]     hi_q, hi_d;
  logic [DATA_W-1:0]     lo_q, lo_d;
  logic [DATA_W-1:0]     addr_q, addr_d;
  logic [DATA_W-1:0]     reg2_q, reg2_d;
  logic [ALUOP_W-1:0]    aluop_q, aluop_d;
  logic                  valid_q, valid_d;
  logic [HILO_W-1:0]     hilo_q, hilo_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
`ifdef EX_MEM_EXCEPT_EN
  logic [31:0]           exc_q, exc_d;
  logic [DATA_W-1:0]     iaddr_q, iaddr_d;
  logic                  dslot_q, dslot_d;
`endif

  // Priority: flush > stall_mem (hold) > stall_ex (bubble) > advance.
  always_comb begin
    wd_d    = wd_q;
    wreg_d  = wreg_q;
    wdata_d = wdata_q;
    whilo_d = whilo_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    addr_d  = addr_q;
    reg2_d  = reg2_q;
    aluop_d = aluop_q;
    valid_d = valid_q;
    hilo_d  = hilo_q;
    cnt_d   = cnt_q;
`ifdef EX_MEM_EXCEPT_EN
    exc_d   = exc_q;
    iaddr_d = iaddr_q;
    dslot_d = dslot_q;
`endif
    if (flush || (!stall_mem && stall_ex)) begin
      wd_d    = '0;
      wreg_d  = 1'b0;
      wdata_d = '0;
      whilo_d = 1'b0;
      hi_d    = '0;
      lo_d    = '0;
      addr_d  = '0;
      reg2_d  = '0;
      aluop_d = ALUOP_NOP;
      valid_d = 1'b0;
      // A bubble keeps the madd/msub partial state alive for EX; flush drops it.
      hilo_d  = flush ? '0 : bus.ex_hilo_temp;
      cnt_d   = flush ? '0 : bus.ex_cnt;
`ifdef EX_MEM_EXCEPT_EN
      exc_d   = '0;
      iaddr_d = '0;
      dslot_d = 1'b0;
`endif
    end else if (!stall_mem) begin
      wd_d    = bus.ex_wd;
      wreg_d  = bus.ex_wreg;
      wdata_d = bus.ex_wdata;
      whilo_d = bus.ex_whilo;
      hi_d    = bus.ex_hi;
      lo_d    = bus.ex_lo;
      addr_d  = bus.ex_mem_addr;
      reg2_d  = bus.ex_reg2;
      aluop_d = bus.ex_aluop;
      valid_d = 1'b1;
      hilo_d  = '0;
      cnt_d   = '0;
`ifdef EX_MEM_EXCEPT_EN
      exc_d   = bus.ex_excepttype;
      iaddr_d = bus.ex_inst_addr;
      dslot_d = bus.ex_in_delayslot;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wd_q    <= '0;
      wreg_q  <= 1'b0;
      wdata_q <= '0;
      whilo_q <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      addr_q  <= '0;
      reg2_q  <= '0;
      aluop_q <= ALUOP_NOP;
      valid_q <= 1'b0;
      hilo_q  <= '0;
      cnt_q   <= '0;
`ifdef EX_MEM_EXCEPT_EN
      exc_q   <= '0;
      iaddr_q <= '0;
      dslot_q <= 1'b0;
`endif
    end else begin
      wd_q    <= wd_d;
      wreg_q  <= wreg_d;
      wdata_q <= wdata_d;
      whilo_q <= whilo_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      addr_q  <= addr_d;
      reg2_q  <= reg2_d;
      aluop_q <= aluop_d;
      valid_q <= valid_d;
      hilo_q  <= hilo_d;
      cnt_q   <= cnt_d;
`ifdef EX_MEM_EXCEPT_EN
      exc_q   <= exc_d;
      iaddr_q <= iaddr_d;
      dslot_q <= dslot_d;
`endif
    end
  end

  assign bus.mem_wd       = wd_q;
  assign bus.mem_wreg     = wreg_q;
  assign bus.mem_wdata    = wdata_q;
  assign bus.mem_whilo    = whilo_q;
  assign bus.mem_hi       = hi_q;
  assign bus.mem_lo       = lo_q;
  assign bus.mem_mem_addr = addr_q;
  assign bus.mem_reg2     = reg2_q;
  assign bus.mem_aluop    = aluop_q;
  assign bus.mem_valid    = valid_q;
  assign bus.hilo_o       = hilo_q;
  assign bus.cnt_o        = cnt_q;
`ifdef EX_MEM_EXCEPT_EN
  assign bus.mem_excepttype   = exc_q;
  assign bus.mem_inst_addr    = iaddr_q;
  assign bus.mem_in_delayslot = dslot_q;
`endif
endmodule

// File: tb/tb_ex_mem_pipe.sv
// Scoreboard bench for ex_mem_pipe: expected outputs are queued as stimulus is applied
// and popped after each clock edge; directed cases cover reset, advance, bubble, hold, flush.
module tb_ex_mem_pipe;
  logic clk;
  logic rst;
  logic stall_ex;
  logic stall_mem;
  logic flush;

  ex_mem_pipe_if bus ();

  ex_mem_pipe dut (
    .clk       (clk),
    .rst       (rst),
    .stall_ex  (stall_ex),
    .stall_mem (stall_mem),
    .flush     (flush),
    .bus       (bus)
  );

  typedef struct packed {
    logic [4:0]  wd;
    logic        wreg;
    logic [31:0] wdata;
    logic        whilo;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] addr;
    logic [31:0] reg2;
    logic [7:0]  aluop;
    logic        valid;
    logic [63:0] hilo;
    logic [1:0]  cnt;
    logic [31:0] exc;
    logic [31:0] iaddr;
    logic        dslot;
  } st_t;

  st_t mdl;
  st_t exp_q[$];
  int  n_cmp = 0;
  int  n_err = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference behaviour of one clock edge given the current inputs.
  function automatic st_t model_next(input st_t c);
    st_t n;
    n = c;
    if (flush) begin
      n = '0;
    end else if (stall_mem) begin
      n = c;
    end else if (stall_ex) begin
      n      = '0;
      n.hilo = bus.ex_hilo_temp;
      n.cnt  = bus.ex_cnt;
    end else begin
      n       = '0;
      n.wd    = bus.ex_wd;
      n.wreg  = bus.ex_wreg;
      n.wdata = bus.ex_wdata;
      n.whilo = bus.ex_whilo;
      n.hi    = bus.ex_hi;
      n.lo    = bus.ex_lo;
      n.addr  = bus.ex_mem_addr;
      n.reg2  = bus.ex_reg2;
      n.aluop = bus.ex_aluop;
      n.valid = 1'b1;
`ifdef EX_MEM_EXCEPT_EN
      n.exc   = bus.ex_excepttype;
      n.iaddr = bus.ex_inst_addr;
      n.dslot = bus.ex_in_delayslot;
`endif
    end
    return n;
  endfunction

  task automatic compare_out(input string tag, input st_t e);
    check_eq({tag, ".wd"},    64'(bus.mem_wd),       64'(e.wd));
    check_eq({tag, ".wreg"},  64'(bus.mem_wreg),     64'(e.wreg));
    check_eq({tag, ".wdata"}, 64'(bus.mem_wdata),    64'(e.wdata));
    check_eq({tag, ".whilo"}, 64'(bus.mem_whilo),    64'(e.whilo));
    check_eq({tag, ".hi"},    64'(bus.mem_hi),       64'(e.hi));
    check_eq({tag, ".lo"},    64'(bus.mem_lo),       64'(e.lo));
    check_eq({tag, ".addr"},  64'(bus.mem_mem_addr), 64'(e.addr));
    check_eq({tag, ".reg2"},  64'(bus.mem_reg2),     64'(e.reg2));
    check_eq({tag, ".aluop"}, 64'(bus.mem_aluop),    64'(e.aluop));
    check_eq({tag, ".valid"}, 64'(bus.mem_valid),    64'(e.valid));
    check_eq({tag, ".hilo"},  64'(bus.hilo_o),       e.hilo);
    check_eq({tag, ".cnt"},   64'(bus.cnt_o),        64'(e.cnt));
`ifdef EX_MEM_EXCEPT_EN
    check_eq({tag, ".exc"},   64'(bus.mem_excepttype),   64'(e.exc));
    check_eq({tag, ".iaddr"}, 64'(bus.mem_inst_addr),    64'(e.iaddr));
    check_eq({tag, ".dslot"}, 64'(bus.mem_in_delayslot), 64'(e.dslot));
`endif
  endtask

  // Queue the expectation, take one edge, then pop and compare 1 time unit later.
  task automatic cycle(input string tag);
    st_t e;
    mdl = model_next(mdl);
    exp_q.push_back(mdl);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      check_eq({tag, ".sb_empty"}, 64'd1, 64'd0);
    end else begin
      e = exp_q.pop_front();
      compare_out(tag, e);
    end
  endtask

  task automatic set_ex_all(input logic v);
    bus.ex_wd        = {5{v}};
    bus.ex_wreg      = v;
    bus.ex_wdata     = {32{v}};
    bus.ex_whilo     = v;
    bus.ex_hi        = {32{v}};
    bus.ex_lo        = {32{v}};
    bus.ex_mem_addr  = {32{v}};
    bus.ex_reg2      = {32{v}};
    bus.ex_aluop     = {8{v}};
    bus.ex_hilo_temp = {64{v}};
    bus.ex_cnt       = {2{v}};
`ifdef EX_MEM_EXCEPT_EN
    bus.ex_excepttype   = {32{v}};
    bus.ex_inst_addr    = {32{v}};
    bus.ex_in_delayslot = v;
`endif
  endtask

  task automatic set_ex_rand();
    bus.ex_wd        = 5'($urandom);
    bus.ex_wreg      = 1'($urandom);
    bus.ex_wdata     = $urandom;
    bus.ex_whilo     = 1'($urandom);
    bus.ex_hi        = $urandom;
    bus.ex_lo        = $urandom;
    bus.ex_mem_addr  = $urandom;
    bus.ex_reg2      = $urandom;
    bus.ex_aluop     = 8'($urandom);
    bus.ex_hilo_temp = {$urandom, $urandom};
    bus.ex_cnt       = 2'($urandom);
`ifdef EX_MEM_EXCEPT_EN
    bus.ex_excepttype   = $urandom;
    bus.ex_inst_addr    = $urandom;
    bus.ex_in_delayslot = 1'($urandom);
`endif
  endtask

  initial begin
    st_t zero;
    zero      = '0;
    mdl       = '0;
    rst       = 1'b1;
    stall_ex  = 1'b0;
    stall_mem = 1'b0;
    flush     = 1'b0;
    set_ex_all(1'b1);

    // Asynchronous reset: outputs clear before any clock edge.
    #2 rst = 1'b0;
    #1 compare_out("rst_async", zero);
    repeat (2) @(posedge clk);
    #1 compare_out("rst_held", zero);
    rst = 1'b1;
    mdl = '0;

    // Advance.
    set_ex_all(1'b0);
    bus.ex_wd    = 5'd5;
    bus.ex_wreg  = 1'b1;
    bus.ex_wdata = 32'hDEAD_BEEF;
    bus.ex_aluop = 8'h21;
    cycle("advance");
    check_eq("advance_wdata", 64'(bus.mem_wdata), 64'h0000_0000_DEAD_BEEF);
    check_eq("advance_valid", 64'(bus.mem_valid), 64'd1);

    // Bubble keeps the multi-cycle state, release clears it.
    stall_ex         = 1'b1;
    bus.ex_hilo_temp = 64'h1_0000_0002;
    bus.ex_cnt       = 2'd1;
    cycle("bubble");
    check_eq("bubble_hilo", bus.hilo_o, 64'h1_0000_0002);
    check_eq("bubble_cnt",  64'(bus.cnt_o), 64'd1);
    check_eq("bubble_aluop", 64'(bus.mem_aluop), 64'd0);
    stall_ex = 1'b0;
    cycle("release");
    check_eq("release_hilo", bus.hilo_o, 64'd0);

    // Hold under stall_mem while EX inputs change.
    bus.ex_wdata = 32'h1234_5678;
    cycle("load");
    stall_mem = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_ex_rand();
      cycle("hold");
    end
    check_eq("hold_wdata", 64'(bus.mem_wdata), 64'h1234_5678);
    check_eq("hold_valid", 64'(bus.mem_valid), 64'd1);

    // Flush beats stall_mem.
    flush = 1'b1;
    cycle("flush_prio");
    check_eq("flush_valid", 64'(bus.mem_valid), 64'd0);
    flush     = 1'b0;
    stall_mem = 1'b0;

`ifdef EX_MEM_EXCEPT_EN
    bus.ex_excepttype   = 32'h0000_0200;
    bus.ex_in_delayslot = 1'b1;
    cycle("exc_adv");
    check_eq("exc_type",  64'(bus.mem_excepttype), 64'h200);
    check_eq("exc_dslot", 64'(bus.mem_in_delayslot), 64'd1);
    flush = 1'b1;
    cycle("exc_flush");
    check_eq("exc_flush_type", 64'(bus.mem_excepttype), 64'd0);
    flush = 1'b0;
`endif

    // Reset asserted mid-bubble clears the held partial product without a clock.
    stall_ex         = 1'b1;
    bus.ex_hilo_temp = 64'hCAFE_F00D_0BAD_BEEF;
    bus.ex_cnt       = 2'd2;
    cycle("pre_rst");
    rst = 1'b0;
    #1;
    check_eq("midrst_hilo", bus.hilo_o, 64'd0);
    check_eq("midrst_cnt",  64'(bus.cnt_o), 64'd0);
    compare_out("midrst", zero);
    mdl = '0;
    #1 rst = 1'b1;
    stall_ex = 1'b0;

    // Random traffic.
    for (int i = 0; i < 300; i++) begin
      set_ex_rand();
      flush     = ($urandom_range(15) == 0);
      stall_mem = ($urandom_range(5) == 0);
      stall_ex  = ($urandom_range(3) == 0);
      cycle("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
